uart_fifo_core: RTL and testbench
=================================

Name: uart_fifo_core

Overview:
Parametrised full-duplex UART with built-in TX and RX FIFOs. Data width, parity mode, stop-bit count, bit period and FIFO depth are all configurable. Received words are queued together with their per-word parity and framing status, and a sticky overrun flag records dropped frames. It is the drop-in successor to the fixed 8-bit, unbuffered UART top, sitting between the host bus logic and the serial pins.

Parameters:
DATA_BITS, 8, payload bits per frame (5..9).
PARITY, 0, 0 = none, 1 = even, 2 = odd.
STOP_BITS, 1, 1 or 2.
CLKS_PER_BIT, 16, clk cycles per serial bit (>= 4, even).
FIFO_DEPTH, 8, entries per FIFO (power of 2, >= 2).

Ports:
clk  in  1  single system clock; all logic is on its rising edge.
rst  in  1  synchronous, active-high reset.
write  in  1  push tx_data into the TX FIFO when txrdy = 1.
tx_data  in  DATA_BITS  word to transmit.
tx  out  1  serial output; idles high.
txrdy  out  1  TX FIFO not full.
tx_busy  out  1  frame in progress or TX FIFO non-empty.
read  in  1  pop the RX FIFO head when rxrdy = 1.
rx  in  1  asynchronous serial input.
rxrdy  out  1  RX FIFO not empty.
rx_data  out  DATA_BITS  head word of the RX FIFO (first-word fall-through).
parityerr  out  1  parity error flag of the head word.
framingerr  out  1  framing error flag of the head word.
overrun  out  1  sticky: a completed frame was dropped because the RX FIFO was full.
rx_level  out  $clog2(FIFO_DEPTH)+1  RX FIFO occupancy.

Behaviour:
- Reset: tx = 1; txrdy = 1; tx_busy = 0; rxrdy = 0; rx_level = 0; parityerr, framingerr and overrun = 0; rx_data = 0. Both FIFOs are emptied. Both FSMs go to IDLE, and the rx synchroniser flops are set to 1. Reset takes effect on the next edge even mid-frame: tx returns high and any partial frame is discarded.
- TX FIFO:
  - write && txrdy stores the word on that edge.
  - write while full is ignored, with no error flag.
  - A pop on the same edge does not make room for a write on that edge.
- TX FSM states: IDLE -> START -> DATA -> PAR (only when PARITY != 0) -> STOP -> IDLE.
  - In IDLE with the FIFO non-empty, the FSM pops the head and enters START. tx goes low on the edge after the word was written.
  - Each bit is held for exactly CLKS_PER_BIT cycles. Data is sent LSB first.
  - The parity bit is the XOR of the data bits for even parity, or its inverse for odd parity.
  - STOP holds tx high for STOP_BITS × CLKS_PER_BIT cycles.
  - From the end of STOP, the next start bit begins immediately if the FIFO is non-empty; there is no extra idle cycle.
- RX path: rx passes through a 2-flop synchroniser first. All further RX logic uses the synchronised value.
- RX FSM states: IDLE -> START -> DATA -> PAR -> STOP -> IDLE.
  - IDLE: a falling edge starts a counter. At CLKS_PER_BIT/2 cycles the line is sampled. If it is still low, the FSM moves on; if it is high, the event is a glitch and the FSM returns to IDLE with nothing recorded.
  - Each following bit is sampled every CLKS_PER_BIT cycles at mid-bit.
  - parityerr_word = received parity bit != expected parity.
  - framingerr_word = 1 if any stop-bit sample is 0.
  - After the last stop sample, the FSM pushes {framingerr, parityerr, data} and returns to IDLE. It can detect a new start bit on the next cycle.
- RX FIFO:
  - A push succeeds if the FIFO is not full, or if read && rxrdy on the same edge.
  - Otherwise the frame is dropped and overrun is set to 1.
  - overrun clears on any edge with read = 1, unless a new overrun occurs on that same edge (set wins).
  - read while empty is ignored.
  - rx_data and the two error flags track the head entry combinationally.
- Pointers wrap modulo FIFO_DEPTH. Each FIFO uses a separate count register, so full and empty are unambiguous.

Test Plan:
1. Basic TX frame (CLKS_PER_BIT = 4, even parity, 1 stop): write 0xA5 -> starting one cycle later, tx reads 0,1,0,1,0,0,1,0,1,0,1 with 4 cycles per bit (44 cycles total), then stays high; tx_busy falls after the stop bit.
2. Loopback (tx tied to rx): write 0x3C, 0xFF, 0x00 back-to-back -> rx_level reaches 3; each read pops in order; parityerr = framingerr = 0 throughout.
3. Error injection (driving rx directly): frame 0x55 with parity bit 1 -> head word 0x55 with parityerr = 1. Next frame has stop bit 0 -> framingerr = 1 with that frame's word.
4. Overrun (FIFO_DEPTH = 4): receive 5 frames without reading -> first 4 retained and overrun = 1 after frame 5; one read gives the first word, rx_level = 3, overrun = 0.
5. Glitch and reset: a 1-cycle low pulse on rx -> no push. Then assert rst for 1 cycle in the middle of a TX data bit -> tx = 1 on the next edge, txrdy = 1, tx_busy = 0, FIFOs empty.
6. TX full (FIFO_DEPTH = 4): write 6 words on consecutive cycles -> 5 are accepted (one popped early), txrdy is 0 during the 6th write, and the 6th word is never transmitted.

Source files
------------

// File: rtl/uart_fifo_core_if.sv
// uart_fifo_core_if
//   Host-side bus of the buffered UART: the TX FIFO push port, the RX FIFO pop
//   port with its head-word status, and the occupancy/status flags.
//   master : host bus logic (drives write, tx_data, read)
//   slave  : uart_fifo_core
//   Signals:
//     write, tx_data      push a word into the TX FIFO when txrdy = 1
//     txrdy, tx_busy      TX FIFO not full / transmitter or TX FIFO busy
//     read                pop the RX FIFO head when rxrdy = 1
//     rxrdy, rx_data      RX FIFO not empty / head word (fall-through)
//     parityerr           parity error flag of the head word
//     framingerr          framing error flag of the head word
//     overrun             sticky dropped-frame flag
//     rx_level            RX FIFO occupancy
interface uart_fifo_core_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 8
);
  logic                          write;
  logic [DATA_BITS-1:0]          tx_data;
  logic                          txrdy;
  logic                          tx_busy;
  logic                          read;
  logic                          rxrdy;
  logic [DATA_BITS-1:0]          rx_data;
  logic                          parityerr;
  logic                          framingerr;
  logic                          overrun;
  logic [$clog2(FIFO_DEPTH):0]   rx_level;

  modport master (
    output write, tx_data, read,
    input  txrdy, tx_busy, rxrdy, rx_data, parityerr, framingerr, overrun, rx_level
  );

  modport slave (
    input  write, tx_data, read,
    output txrdy, tx_busy, rxrdy, rx_data, parityerr, framingerr, overrun, rx_level
  );
endinterface

// File: rtl/uart_fifo_core.sv
// uart_fifo_core
//   Full-duplex UART with a TX FIFO feeding the serialiser and an RX FIFO
//   that stores each received word together with its parity and framing
//   status. Frames: start, DATA_BITS data bits LSB first, optional parity,
//   STOP_BITS stop bits, each bit CLKS_PER_BIT clocks long.
//   Ports:
//     clk   system clock, all logic on the rising edge
//     rst   synchronous active-high reset
//     bus   host bus (uart_fifo_core_if.slave)
//     tx    serial output, idles high
//     rx    asynchronous serial input
module uart_fifo_core #(
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic            clk,
  input  logic            rst,
  uart_fifo_core_if.slave bus,
  output logic            tx,
  input  logic            rx
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TIM_W = $clog2(CLKS_PER_BIT);
  localparam int RXW   = DATA_BITS + 2;
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [TIM_W-1:0] TICK_LAST = TIM_W'(CLKS_PER_BIT - 1);
  localparam logic [TIM_W-1:0] TICK_HALF = TIM_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [3:0]       BIT_LAST  = 4'(DATA_BITS - 1);
  localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);
  localparam bit HAS_PARITY = (PARITY != 0);
  localparam bit ODD_PARITY = (PARITY == 2);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  // ---------------------------------------------------------------- TX FIFO
  logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     tx_wr_ptr_reg, tx_rd_ptr_reg;
  logic [CNT_W-1:0]     tx_count_reg;
  logic                 tx_full, tx_empty, tx_push, tx_pop;
  logic [DATA_BITS-1:0] tx_head;

  // Fullness comes from the registered count only, so a pop on the same edge
  // never frees room for a write.
  assign tx_full  = (tx_count_reg == DEPTH_C);
  assign tx_empty = (tx_count_reg == '0);
  assign tx_push  = bus.write && !tx_full;
  assign tx_head  = tx_mem[tx_rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr_reg] <= bus.tx_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wr_ptr_reg <= '0;
      tx_rd_ptr_reg <= '0;
      tx_count_reg  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr_reg <= tx_wr_ptr_reg + 1'b1;
      if (tx_pop)  tx_rd_ptr_reg <= tx_rd_ptr_reg + 1'b1;
      tx_count_reg <= tx_count_reg + CNT_W'(tx_push) - CNT_W'(tx_pop);
    end
  end

  // ---------------------------------------------------------------- TX FSM
  state_t               tx_state_reg;
  logic [TIM_W-1:0]     tx_tick_reg;
  logic [3:0]           tx_bit_reg;
  logic [DATA_BITS-1:0] tx_shift_reg;
  logic                 tx_par_reg;
  logic                 tx_reg;
  logic                 tx_bit_done;

  assign tx_bit_done = (tx_tick_reg == TICK_LAST);
  // Pop when idle, or at the very end of the last stop bit so the next start
  // bit follows without an idle cycle.
  assign tx_pop = !tx_empty &&
                  ((tx_state_reg == S_IDLE) ||
                   (tx_state_reg == S_STOP && tx_bit_done && tx_bit_reg == STOP_LAST));

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_reg <= S_IDLE;
      tx_tick_reg  <= '0;
      tx_bit_reg   <= '0;
      tx_shift_reg <= '0;
      tx_par_reg   <= 1'b0;
      tx_reg       <= 1'b1;
    end else begin
      case (tx_state_reg)
        S_IDLE: begin
          if (tx_pop) begin
            tx_state_reg <= S_START;
            tx_reg       <= 1'b0;
            tx_tick_reg  <= '0;
            tx_shift_reg <= tx_head;
            tx_par_reg   <= (^tx_head) ^ ODD_PARITY;
          end
        end
        S_START: begin
          if (tx_bit_done) begin
            tx_tick_reg  <= '0;
            tx_bit_reg   <= '0;
            tx_state_reg <= S_DATA;
            tx_reg       <= tx_shift_reg[0];
            tx_shift_reg <= tx_shift_reg >> 1;
          end else tx_tick_reg <= tx_tick_reg + 1'b1;
        end
        S_DATA: begin
          if (tx_bit_done) begin
            tx_tick_reg <= '0;
            if (tx_bit_reg == BIT_LAST) begin
              tx_bit_reg <= '0;
              if (HAS_PARITY) begin
                tx_state_reg <= S_PAR;
                tx_reg       <= tx_par_reg;
              end else begin
                tx_state_reg <= S_STOP;
                tx_reg       <= 1'b1;
              end
            end else begin
              tx_bit_reg   <= tx_bit_reg + 4'd1;
              tx_reg       <= tx_shift_reg[0];
              tx_shift_reg <= tx_shift_reg >> 1;
            end
          end else tx_tick_reg <= tx_tick_reg + 1'b1;
        end
        S_PAR: begin
          if (tx_bit_done) begin
            tx_tick_reg  <= '0;
            tx_bit_reg   <= '0;
            tx_state_reg <= S_STOP;
            tx_reg       <= 1'b1;
          end else tx_tick_reg <= tx_tick_reg + 1'b1;
        end
        S_STOP: begin
          if (tx_bit_done) begin
            tx_tick_reg <= '0;
            if (tx_bit_reg == STOP_LAST) begin
              tx_bit_reg <= '0;
              if (tx_pop) begin
                tx_state_reg <= S_START;
                tx_reg       <= 1'b0;
                tx_shift_reg <= tx_head;
                tx_par_reg   <= (^tx_head) ^ ODD_PARITY;
              end else tx_state_reg <= S_IDLE;
            end else tx_bit_reg <= tx_bit_reg + 4'd1;
          end else tx_tick_reg <= tx_tick_reg + 1'b1;
        end
        default: tx_state_reg <= S_IDLE;
      endcase
    end
  end

  assign tx          = tx_reg;
  assign bus.txrdy   = !tx_full;
  assign bus.tx_busy = (tx_state_reg != S_IDLE) || !tx_empty;

  // ------------------------------------------------------- RX synchroniser
  // Third flop (prev) gives the previous synchronised value for edge detect.
  logic rx_meta_reg, rx_sync_reg, rx_prev_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_reg <= 1'b1;
      rx_sync_reg <= 1'b1;
      rx_prev_reg <= 1'b1;
    end else begin
      rx_meta_reg <= rx;
      rx_sync_reg <= rx_meta_reg;
      rx_prev_reg <= rx_sync_reg;
    end
  end

  // ---------------------------------------------------------------- RX FSM
  state_t               rx_state_reg;
  logic [TIM_W-1:0]     rx_tick_reg;
  logic [3:0]           rx_bit_reg;
  logic [DATA_BITS-1:0] rx_shift_reg;
  logic                 rx_perr_reg, rx_ferr_reg;
  logic                 rx_push_reg;
  logic [RXW-1:0]       rx_word_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_reg <= S_IDLE;
      rx_tick_reg  <= '0;
      rx_bit_reg   <= '0;
      rx_shift_reg <= '0;
      rx_perr_reg  <= 1'b0;
      rx_ferr_reg  <= 1'b0;
      rx_push_reg  <= 1'b0;
      rx_word_reg  <= '0;
    end else begin
      rx_push_reg <= 1'b0;
      case (rx_state_reg)
        S_IDLE: begin
          if (rx_prev_reg && !rx_sync_reg) begin
            rx_state_reg <= S_START;
            rx_tick_reg  <= '0;
          end
        end
        S_START: begin
          // Mid start bit: still low means a real start, high means a glitch.
          if (rx_tick_reg == TICK_HALF) begin
            rx_tick_reg <= '0;
            rx_bit_reg  <= '0;
            rx_perr_reg <= 1'b0;
            rx_ferr_reg <= 1'b0;
            rx_state_reg <= rx_sync_reg ? S_IDLE : S_DATA;
          end else rx_tick_reg <= rx_tick_reg + 1'b1;
        end
        S_DATA: begin
          if (rx_tick_reg == TICK_LAST) begin
            rx_tick_reg  <= '0;
            rx_shift_reg <= {rx_sync_reg, rx_shift_reg[DATA_BITS-1:1]};
            if (rx_bit_reg == BIT_LAST) begin
              rx_bit_reg   <= '0;
              rx_state_reg <= HAS_PARITY ? S_PAR : S_STOP;
            end else rx_bit_reg <= rx_bit_reg + 4'd1;
          end else rx_tick_reg <= rx_tick_reg + 1'b1;
        end
        S_PAR: begin
          if (rx_tick_reg == TICK_LAST) begin
            rx_tick_reg  <= '0;
            rx_perr_reg  <= rx_sync_reg ^ (^rx_shift_reg) ^ ODD_PARITY;
            rx_state_reg <= S_STOP;
          end else rx_tick_reg <= rx_tick_reg + 1'b1;
        end
        S_STOP: begin
          if (rx_tick_reg == TICK_LAST) begin
            rx_tick_reg <= '0;
            if (rx_bit_reg == STOP_LAST) begin
              rx_bit_reg   <= '0;
              rx_push_reg  <= 1'b1;
              rx_word_reg  <= {rx_ferr_reg | ~rx_sync_reg, rx_perr_reg, rx_shift_reg};
              rx_state_reg <= S_IDLE;
            end else begin
              rx_ferr_reg <= rx_ferr_reg | ~rx_sync_reg;
              rx_bit_reg  <= rx_bit_reg + 4'd1;
            end
          end else rx_tick_reg <= rx_tick_reg + 1'b1;
        end
        default: rx_state_reg <= S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- RX FIFO
  logic [RXW-1:0]   rx_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rx_wr_ptr_reg, rx_rd_ptr_reg;
  logic [CNT_W-1:0] rx_count_reg;
  logic             rx_overrun_reg;
  logic             rx_nonempty, rx_pop, rx_push_ok;

  assign rx_nonempty = (rx_count_reg != '0);
  assign rx_pop      = bus.read && rx_nonempty;
  // A simultaneous pop frees a slot for the incoming frame.
  assign rx_push_ok  = rx_push_reg && ((rx_count_reg != DEPTH_C) || rx_pop);

  always_ff @(posedge clk) begin
    if (rx_push_ok) rx_mem[rx_wr_ptr_reg] <= rx_word_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wr_ptr_reg  <= '0;
      rx_rd_ptr_reg  <= '0;
      rx_count_reg   <= '0;
      rx_overrun_reg <= 1'b0;
    end else begin
      if (rx_push_ok) rx_wr_ptr_reg <= rx_wr_ptr_reg + 1'b1;
      if (rx_pop)     rx_rd_ptr_reg <= rx_rd_ptr_reg + 1'b1;
      rx_count_reg <= rx_count_reg + CNT_W'(rx_push_ok) - CNT_W'(rx_pop);
      if (rx_push_reg && !rx_push_ok) rx_overrun_reg <= 1'b1;
      else if (bus.read)              rx_overrun_reg <= 1'b0;
    end
  end

  // Head outputs read as zero while empty so stale RAM never shows.
  assign {bus.framingerr, bus.parityerr, bus.rx_data} =
      rx_nonempty ? rx_mem[rx_rd_ptr_reg] : '0;
  assign bus.rxrdy    = rx_nonempty;
  assign bus.overrun  = rx_overrun_reg;
  assign bus.rx_level = rx_count_reg;
endmodule

// File: tb/tb_uart_fifo_core.sv
// tb_uart_fifo_core
//   Directed/randomised bench for uart_fifo_core (8 data bits, even parity,
//   1 stop bit, 4 clocks per bit, 4-entry FIFOs). Expected values come from a
//   frame-level model: serial bit lists built from the word, a queue of
//   received entries with a capacity limit, and a decoder for the tx trace.
module tb_uart_fifo_core;
  localparam int DB    = 8;
  localparam int PAR   = 1;
  localparam int SB    = 1;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = (1 + DB + 1 + SB) * CPB;

  logic clk = 1'b0;
  logic rst;
  logic tx, rx, rx_drv, loop_en;

  always #5 clk = ~clk;

  uart_fifo_core_if #(.DATA_BITS(DB), .FIFO_DEPTH(DEPTH)) bus ();

  assign rx = loop_en ? tx : rx_drv;

  uart_fifo_core #(
    .DATA_BITS(DB), .PARITY(PAR), .STOP_BITS(SB),
    .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .tx(tx), .rx(rx)
  );

  int checks = 0;
  int errors = 0;

  bit         tx_trace[$];
  logic [9:0] rxq[$];          // model: {framingerr, parityerr, data}
  bit         ovr_model = 1'b0;
  logic [7:0] dec_words[$];
  bit         dec_pars[$];
  bit         dec_stops[$];
  int         dec_starts[$];
  logic [7:0] w;
  logic [7:0] words[6];
  bit         exp_bits[$];
  int         zeros;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    tx_trace.push_back(tx);
  endtask

  task automatic model_rx(input logic [7:0] d, input bit p, input bit s);
    logic [9:0] e;
    e = {~s, p ^ (^d), d};
    if (rxq.size() < DEPTH) rxq.push_back(e);
    else ovr_model = 1'b1;
  endtask

  task automatic host_write(input logic [7:0] d);
    bus.write   = 1'b1;
    bus.tx_data = d;
    $display("tx write data=%02h txrdy=%0b", d, bus.txrdy);
    step();
    bus.write = 1'b0;
  endtask

  // Drive one serial frame onto rx with explicit parity and stop values.
  task automatic send_rx(input logic [7:0] d, input bit p, input bit s, input string tag);
    bit bits[11];
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = d[i];
    bits[9]  = p;
    bits[10] = s;
    for (int b = 0; b < 11; b++) begin
      rx_drv = bits[b];
      for (int c = 0; c < CPB; c++) step();
    end
    rx_drv = 1'b1;
    for (int c = 0; c < 6; c++) step();
    model_rx(d, p, s);
    $display("rx frame data=%02h par=%0b stop=%0b level=%0d overrun=%0b",
             d, p, s, bus.rx_level, bus.overrun);
    chk({tag, "_level"}, bus.rx_level, rxq.size());
    chk({tag, "_overrun"}, bus.overrun, ovr_model);
  endtask

  task automatic read_check(input string tag);
    logic [9:0] e;
    e = (rxq.size() > 0) ? rxq.pop_front() : 10'h0;
    $display("rx read data=%02h perr=%0b ferr=%0b", bus.rx_data, bus.parityerr, bus.framingerr);
    chk({tag, "_rxrdy"}, bus.rxrdy, 1);
    chk({tag, "_data"}, bus.rx_data, e[7:0]);
    chk({tag, "_perr"}, bus.parityerr, e[8]);
    chk({tag, "_ferr"}, bus.framingerr, e[9]);
    bus.read = 1'b1;
    step();
    bus.read = 1'b0;
    ovr_model = 1'b0;
    chk({tag, "_level_after"}, bus.rx_level, rxq.size());
    chk({tag, "_overrun_after"}, bus.overrun, ovr_model);
  endtask

  task automatic wait_level(input int n, input int budget, input string tag);
    int k = 0;
    while (bus.rx_level != n && k < budget) begin
      step();
      k++;
    end
    chk(tag, bus.rx_level, n);
  endtask

  // Recover frames from the recorded tx trace by mid-bit sampling.
  task automatic decode_trace();
    int i = 0;
    dec_words.delete(); dec_pars.delete(); dec_stops.delete(); dec_starts.delete();
    while (i + FRAME <= tx_trace.size()) begin
      if (tx_trace[i] == 1'b0) begin
        logic [7:0] d;
        for (int k = 0; k < 8; k++) d[k] = tx_trace[i + CPB*(k+1) + CPB/2];
        dec_words.push_back(d);
        dec_pars.push_back(tx_trace[i + CPB*9 + CPB/2]);
        dec_stops.push_back(tx_trace[i + CPB*10 + CPB/2]);
        dec_starts.push_back(i);
        i += FRAME;
      end else i++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rx_drv = 1'b1; loop_en = 1'b0;
    bus.write = 1'b0; bus.tx_data = '0; bus.read = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();

    // Reset state
    chk("rst_tx", tx, 1);
    chk("rst_txrdy", bus.txrdy, 1);
    chk("rst_tx_busy", bus.tx_busy, 0);
    chk("rst_rxrdy", bus.rxrdy, 0);
    chk("rst_level", bus.rx_level, 0);
    chk("rst_perr", bus.parityerr, 0);
    chk("rst_ferr", bus.framingerr, 0);
    chk("rst_overrun", bus.overrun, 0);
    chk("rst_rx_data", bus.rx_data, 0);

    // 1: exact TX waveform for 0xA5
    host_write(8'hA5);
    tx_trace.delete();
    repeat (FRAME) step();
    exp_bits.delete();
    exp_bits.push_back(1'b0);
    w = 8'hA5;
    for (int i = 0; i < 8; i++) exp_bits.push_back(w[i]);
    exp_bits.push_back(^w);
    exp_bits.push_back(1'b1);
    for (int i = 0; i < FRAME; i++) chk("t1_tx_bit", tx_trace[i], exp_bits[i / CPB]);
    chk("t1_busy_in_stop", bus.tx_busy, 1);
    step();
    chk("t1_busy_after", bus.tx_busy, 0);
    chk("t1_tx_idle", tx, 1);

    // 2: loopback, directed then random words
    loop_en = 1'b1;
    step();
    host_write(8'h3C); host_write(8'hFF); host_write(8'h00);
    model_rx(8'h3C, 1'b0, 1'b1); model_rx(8'hFF, 1'b0, 1'b1); model_rx(8'h00, 1'b0, 1'b1);
    wait_level(3, 4 * FRAME, "t2_level3");
    chk("t2_overrun", bus.overrun, 0);
    repeat (3) read_check("t2_read");
    for (int i = 0; i < 4; i++) begin
      w = 8'($urandom);
      host_write(w);
      model_rx(w, ^w, 1'b1);
    end
    wait_level(4, 5 * FRAME, "t2_level4");
    repeat (4) read_check("t2_rand_read");
    for (int k = 0; k < 100 && bus.tx_busy; k++) step();
    chk("t2_tx_done", bus.tx_busy, 0);
    loop_en = 1'b0;
    repeat (4) step();

    // 3: parity and framing error injection
    send_rx(8'h55, 1'b1, 1'b1, "t3_perr");
    w = 8'($urandom);
    send_rx(w, ^w, 1'b0, "t3_ferr");
    for (int i = 0; i < 2; i++) begin
      w = 8'($urandom);
      send_rx(w, (^w) ^ 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "t3_rand");
    end
    repeat (4) read_check("t3_read");

    // 4: overrun with five frames and no reads
    for (int i = 0; i < 5; i++) begin
      w = 8'($urandom);
      send_rx(w, ^w, 1'b1, "t4_frame");
    end
    chk("t4_overrun_set", bus.overrun, 1);
    repeat (4) read_check("t4_read");

    // 5: glitch, then reset mid-frame
    rx_drv = 1'b0;
    step();
    rx_drv = 1'b1;
    repeat (12) step();
    chk("t5_glitch_level", bus.rx_level, 0);
    chk("t5_glitch_rxrdy", bus.rxrdy, 0);
    w = 8'($urandom);
    send_rx(w, ^w, 1'b1, "t5_pre");
    w = 8'($urandom) & 8'hF0;
    host_write(w);
    host_write(8'($urandom));
    repeat (9) step();
    chk("t5_tx_mid_bit", tx, 0);
    chk("t5_busy_mid", bus.tx_busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    rxq.delete();
    ovr_model = 1'b0;
    chk("t5_tx", tx, 1);
    chk("t5_txrdy", bus.txrdy, 1);
    chk("t5_tx_busy", bus.tx_busy, 0);
    chk("t5_rxrdy", bus.rxrdy, 0);
    chk("t5_level", bus.rx_level, 0);
    chk("t5_rx_data", bus.rx_data, 0);
    chk("t5_overrun", bus.overrun, 0);
    tx_trace.delete();
    repeat (2 * FRAME) step();
    zeros = 0;
    foreach (tx_trace[i]) if (tx_trace[i] == 1'b0) zeros++;
    chk("t5_tx_stays_idle", zeros, 0);

    // 6: TX FIFO full, six back-to-back writes
    tx_trace.delete();
    for (int i = 0; i < 6; i++) begin
      words[i] = 8'($urandom);
      chk("t6_txrdy", bus.txrdy, (i < 5) ? 1 : 0);
      host_write(words[i]);
    end
    repeat (6 * FRAME) step();
    decode_trace();
    chk("t6_frames", dec_words.size(), 5);
    for (int i = 0; i < 5 && i < dec_words.size(); i++) begin
      $display("tx frame %0d data=%02h par=%0b stop=%0b", i, dec_words[i], dec_pars[i], dec_stops[i]);
      chk("t6_word", dec_words[i], words[i]);
      chk("t6_parity", dec_pars[i], ^words[i]);
      chk("t6_stop", dec_stops[i], 1);
      if (i > 0) chk("t6_gap", dec_starts[i] - dec_starts[i-1], FRAME);
    end
    chk("t6_busy_end", bus.tx_busy, 0);
    chk("t6_txrdy_end", bus.txrdy, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
